dmem_port_arbiter: RTL

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_pkg.sv | 17 +
 rtl/rr_pick.sv | 36 +++
 rtl/dmem_port_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared defaults and FSM encoding for the data-memory port arbiter
package dmem_pkg;

  localparam int DMEM_N_REQ    = 4;
  localparam int DMEM_ADDR_W   = 8;
  localparam int DMEM_DATA_W   = 128;
  localparam int DMEM_MAX_LOCK = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Next requester index in round-robin order, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority picker; search begins at ptr_i and wraps
module rr_pick
  import dmem_pkg::*;
#(
  parameter int N     = DMEM_N_REQ,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  localparam int JW = IDX_W + 1;

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [JW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr_i} + JW'(k);
      if (j >= JW'(N)) j = j - JW'(N);
      if (!vld_o && req_i[j[IDX_W-1:0]]) begin
        vld_o               = 1'b1;
        idx_o               = j[IDX_W-1:0];
        gnt_o[j[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin arbiter with lock and peer-collision stall for one memory port
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int N_REQ    = DMEM_N_REQ,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_LOCK = DMEM_MAX_LOCK
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     peer_we,
  input  logic [ADDR_W-1:0]        peer_addr,
  output logic                     rd_valid,
  output logic [$clog2(N_REQ)-1:0] rd_id,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int LCW   = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] MAX_CNT = LCW'(MAX_LOCK);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d, lock_cnt_inc;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_v1_q, rd_v2_q;
  logic [IDX_W-1:0]  rd_id1_q, rd_id2_q;

  logic [N_REQ-1:0]  owner_oh, elig, win_oh;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld, collide, accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // While locked, everyone but the owner is masked out of the search.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    elig              = (state_q == ST_LOCK) ? (req & owner_oh) : req;
  end

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  assign win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[win_idx*DATA_W +: DATA_W];
  // A peer write landing on the same address next cycle would race ours; stall one cycle.
  assign collide   = peer_we && (peer_addr == win_addr);
  assign accept    = rst_n && win_vld && !collide;
  assign gnt       = accept ? win_oh : '0;

  assign lock_cnt_inc = lock_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (accept) ptr_d = IDX_W'(wrap_inc(int'(win_idx), N_REQ));
    case (state_q)
      ST_IDLE: begin
        if (accept && req_lock[win_idx] && (MAX_LOCK > 1)) begin
          state_d    = ST_LOCK;
          owner_d    = win_idx;
          lock_cnt_d = LCW'(1);
        end
      end
      ST_LOCK: begin
        if (!req_lock[owner_q] || (accept && (lock_cnt_inc == MAX_CNT))) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
          ptr_d      = IDX_W'(wrap_inc(int'(owner_q), N_REQ));
        end else if (accept) begin
          lock_cnt_d = lock_cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_v1_q     <= 1'b0;
      rd_v2_q     <= 1'b0;
      rd_id1_q    <= '0;
      rd_id2_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      mem_we_q   <= accept & req_we[win_idx];
      if (accept) begin
        mem_addr_q  <= win_addr;
        mem_wdata_q <= win_wdata;
      end
      rd_v1_q  <= accept & ~req_we[win_idx];
      rd_id1_q <= win_idx;
      rd_v2_q  <= rd_v1_q;
      rd_id2_q <= rd_id1_q;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_v2_q;
  assign rd_id     = rd_id2_q;
  assign rd_data   = rd_v2_q ? mem_rdata : '0;
  assign busy      = (state_q == ST_LOCK);

endmodule
